// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC result path.
// Ports: none (package). Holds default widths and the running-sum type
// used by the result collector, its FIFO and the bench.
package mac_pkg;

  localparam int MAC_DATA_WIDTH    = 40;
  localparam int MAC_VEC_LEN_WIDTH = 16;
  localparam int MAC_FIFO_DEPTH    = 4;

  // One MAC running sum / one dot-product result at the default width.
  typedef logic [MAC_DATA_WIDTH-1:0] acc_t;

endpackage

// File: rtl/mac_res_fifo.sv
// Synchronous first-word-fall-through FIFO holding completed dot products.
// Ports: clk/rst (sync, active-high), push+din write, pop read, full/empty
// status, head = oldest entry (0 while empty). Push while full is accepted
// only when a pop happens in the same cycle; pop while empty is ignored.
module mac_res_fifo
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_DATA_WIDTH,
  parameter int DEPTH = MAC_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written when full.
  assign do_push = push & (~full | do_pop);

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mac_result_collector.sv
// Slices the never-clearing MAC running-sum stream into per-vector dot
// products (current sum minus sum at the previous boundary) and queues them
// for a valid/ready consumer.
// Ports: i_clk, i_rst (sync, active-high); i_acc_val/i_acc_valid running-sum
// beats; i_vec_len elements per vector (0 means 1); o_dot/o_dot_valid/
// i_dot_ready result handshake (result appears 1 cycle after the boundary
// beat); o_elem_cnt beats seen in the current vector; o_overflow sticky drop.
module mac_result_collector
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH    = MAC_DATA_WIDTH,
  parameter int VEC_LEN_WIDTH = MAC_VEC_LEN_WIDTH,
  parameter int FIFO_DEPTH    = MAC_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_WIDTH-1:0]    i_acc_val,
  input  logic                     i_acc_valid,
  input  logic [VEC_LEN_WIDTH-1:0] i_vec_len,
  output logic [DATA_WIDTH-1:0]    o_dot,
  output logic                     o_dot_valid,
  input  logic                     i_dot_ready,
  output logic [VEC_LEN_WIDTH-1:0] o_elem_cnt,
  output logic                     o_overflow
);

  localparam logic [VEC_LEN_WIDTH-1:0] LEN_ONE = VEC_LEN_WIDTH'(1);

  logic [VEC_LEN_WIDTH-1:0] len_q;
  logic [VEC_LEN_WIDTH-1:0] elem_cnt;
  logic [DATA_WIDTH-1:0]    base;
  logic                     overflow;

  logic [VEC_LEN_WIDTH-1:0] in_len;
  logic [VEC_LEN_WIDTH-1:0] cur_len;
  logic [VEC_LEN_WIDTH:0]   cnt_next;
  logic                     first_beat;
  logic                     boundary;
  logic [DATA_WIDTH-1:0]    dot_res;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic [DATA_WIDTH-1:0]    fifo_head;

  // A zero length would never hit a boundary, so it is treated as one.
  assign in_len     = (i_vec_len == '0) ? LEN_ONE : i_vec_len;
  assign first_beat = (elem_cnt == '0);
  // On the first beat the live length applies immediately, so a length-1
  // vector closes on the very beat that latches it.
  assign cur_len    = first_beat ? in_len : len_q;
  // One bit wider so the compare cannot wrap at the maximum length.
  assign cnt_next   = {1'b0, elem_cnt} + 1'b1;
  assign boundary   = i_acc_valid && (cnt_next == {1'b0, cur_len});
  // Unsigned modular difference handles running-sum wraparound.
  assign dot_res    = i_acc_val - base;

  assign fifo_pop   = ~fifo_empty & i_dot_ready;
  assign fifo_push  = boundary;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_q    <= '0;
      elem_cnt <= '0;
      base     <= '0;
      overflow <= 1'b0;
    end else if (i_acc_valid) begin
      if (first_beat) begin
        len_q <= in_len;
      end
      if (boundary) begin
        elem_cnt <= '0;
        // Base advances even when the result is dropped so that the
        // following vectors are still sliced correctly.
        base     <= i_acc_val;
        if (fifo_full && !fifo_pop) begin
          overflow <= 1'b1;
        end
      end else begin
        elem_cnt <= elem_cnt + 1'b1;
      end
    end
  end

  mac_res_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .din   (dot_res),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign o_dot       = fifo_head;
  assign o_dot_valid = ~fifo_empty;
  assign o_elem_cnt  = elem_cnt;
  assign o_overflow  = overflow;

endmodule
